// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arbiter_pkg;

  // Arbiter ownership: IDLE is only seen between reset and the first grant
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Which master a read response belongs to
  typedef enum logic {
    MID_M0 = 1'b0,
    MID_M1 = 1'b1
  } master_id_e;

  localparam logic [9:0] OUT_ADDR_DEFAULT  = 10'h001;
  localparam int         MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way pick between master requests using the last owner and its burst count.
// Latency: purely combinational.
// Backpressure: the losing master simply sees its grant low.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic          req0_i,
  input  logic          req1_i,
  input  arb_state_e    state_i,
  input  logic [BW-1:0] burst_cnt_i,
  output logic          gnt0_o,
  output logic          gnt1_o
);

  // Lone requester always wins; on contention the owner keeps going until its burst is used up
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && req1_i) begin
      case (state_i)
        ST_OWN0: begin
          if (burst_cnt_i < BW'(MAX_BURST)) gnt0_o = 1'b1;
          else                              gnt1_o = 1'b1;
        end
        ST_OWN1: begin
          if (burst_cnt_i < BW'(MAX_BURST)) gnt1_o = 1'b1;
          else                              gnt0_o = 1'b1;
        end
        default: gnt0_o = 1'b1;
      endcase
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous memory, plus a memory-mapped output byte.
// Latency: grant and memory command in the request cycle; read data and out_valid one cycle later.
// Backpressure: a losing master sees gnt low and must hold its request; nothing is queued here.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [9:0] OUT_ADDR  = OUT_ADDR_DEFAULT,
  parameter int         MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [9:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [9:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  output logic [9:0]  mem_addr,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q;
  logic [BW-1:0] burst_cnt_q;
  logic          pick0, pick1;
  logic          gnt0, gnt1, any_gnt;
  logic          sel_wr, sel_is_out;
  logic [9:0]    sel_addr;
  logic [15:0]   sel_wdata;
  logic [9:0]    mem_addr_d, mem_addr_q;
  logic          rd_vld_q, rd_local_q;
  master_id_e    rd_owner_q;
  logic [7:0]    out_data_q;
  logic          out_valid_q;
  logic [15:0]   rdata;

  mem_arbiter_rr_pick #(
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_pick (
    .req0_i      (m0_req),
    .req1_i      (m1_req),
    .state_i     (state_q),
    .burst_cnt_i (burst_cnt_q),
    .gnt0_o      (pick0),
    .gnt1_o      (pick1)
  );

  // Nothing is granted while reset is held, even with requests pending
  assign gnt0    = pick0 & rst_n;
  assign gnt1    = pick1 & rst_n;
  assign any_gnt = gnt0 | gnt1;
  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;

  // Route the granted master's command fields onto the shared path
  always_comb begin
    sel_wr    = m0_wr;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (gnt1) begin
      sel_wr    = m1_wr;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  assign sel_is_out = (sel_addr == OUT_ADDR);

  // The address bus parks on the last granted address when idle
  assign mem_addr_d = !rst_n  ? 10'h000 :
                      any_gnt ? sel_addr : mem_addr_q;
  assign mem_addr   = mem_addr_d;
  assign mem_wr     = any_gnt & sel_wr & ~sel_is_out;
  assign mem_wdata  = sel_wdata;

  // Arbiter state: last owner and how many grants it has taken back to back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
    end else if (gnt0) begin
      state_q <= ST_OWN0;
      if (state_q != ST_OWN0)                 burst_cnt_q <= BW'(1);
      else if (burst_cnt_q < BW'(MAX_BURST))  burst_cnt_q <= burst_cnt_q + BW'(1);
    end else if (gnt1) begin
      state_q <= ST_OWN1;
      if (state_q != ST_OWN1)                 burst_cnt_q <= BW'(1);
      else if (burst_cnt_q < BW'(MAX_BURST))  burst_cnt_q <= burst_cnt_q + BW'(1);
    end else begin
      burst_cnt_q <= '0;
    end
  end

  // Response tag for the read in flight, held address, and the output byte register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_local_q  <= 1'b0;
      rd_owner_q  <= MID_M0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      rd_vld_q    <= any_gnt & ~sel_wr;
      rd_local_q  <= sel_is_out;
      rd_owner_q  <= gnt1 ? MID_M1 : MID_M0;
      out_valid_q <= any_gnt & sel_wr & sel_is_out;
      if (any_gnt && sel_wr && sel_is_out) out_data_q <= sel_wdata[7:0];
    end
  end

  // Reads of the output register never look at the memory bus
  assign rdata     = rd_local_q ? {8'h00, out_data_q} : mem_rdata;
  assign m0_rdata  = rdata;
  assign m1_rdata  = rdata;
  // A response that lands in a reset cycle is dropped
  assign m0_rvalid = rd_vld_q & (rd_owner_q == MID_M0) & rst_n;
  assign m1_rvalid = rd_vld_q & (rd_owner_q == MID_M1) & rst_n;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q & rst_n;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a reference model.
// Grants and memory commands are checked in-cycle; read and output responses via scoreboard queues.
// Masters hold their request until granted.
module tb_mem_arbiter;

  localparam logic [9:0] OUT_A = 10'h001;
  localparam int         MAXB  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [9:0]  m0_addr, m1_addr, mem_addr;
  logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr, out_valid;
  logic [7:0]  out_data;

  mem_arbiter #(.OUT_ADDR(OUT_A), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the model's own copy of what it should contain
  logic [15:0] sim_mem [512];
  logic [15:0] ref_mem [512];

  always @(posedge clk) begin
    if (mem_wr) sim_mem[mem_addr[9:1]] <= mem_wdata;
    mem_rdata <= sim_mem[mem_addr[9:1]];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  int          own = -1;     // last granted master, -1 before the first grant
  int          streak = 0;   // consecutive grants to own
  logic [7:0]  ref_out = 8'h00;
  logic [9:0]  last_addr = 10'h000;

  // Pending request per master, held until granted
  bit          pv [2];
  bit          pw [2];
  logic [9:0]  pa [2];
  logic [15:0] pd [2];
  bit          rand_mode = 0;
  int          dut_g;

  typedef struct { int m; logic [15:0] d; int due; } rd_t;
  typedef struct { logic [7:0] d; int due; } out_t;
  rd_t  rdq [$];
  out_t oq  [$];

  int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  function automatic int arb(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0) return -1;
    if (own < 0) return 0;
    if (streak < MAXB) return own;
    return 1 - own;
  endfunction

  task automatic gen_req(input int m);
    pv[m] = 1;
    pw[m] = ($urandom_range(0, 1) == 1);
    pa[m] = ($urandom_range(0, 5) == 0) ? OUT_A : 10'($urandom_range(0, 1023));
    pd[m] = 16'($urandom);
  endtask

  // One clock cycle: drive after the edge, check the combinational response mid-cycle
  task automatic step(input logic rst_val);
    int  g;
    rd_t r;
    out_t o;
    @(posedge clk);
    #1;
    rst_n = rst_val;
    if (!rst_val) begin
      rdq.delete();
      oq.delete();
    end
    if (rand_mode)
      for (int m = 0; m < 2; m++)
        if (!pv[m] && $urandom_range(0, 9) < 6) gen_req(m);
    m0_req = pv[0]; m0_wr = pw[0]; m0_addr = pa[0]; m0_wdata = pd[0];
    m1_req = pv[1]; m1_wr = pw[1]; m1_addr = pa[1]; m1_wdata = pd[1];
    @(negedge clk);
    g = rst_val ? arb(pv[0], pv[1]) : -1;
    dut_g = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
    chk("m0_gnt", {31'd0, m0_gnt}, (g == 0) ? 1 : 0);
    chk("m1_gnt", {31'd0, m1_gnt}, (g == 1) ? 1 : 0);
    if (g >= 0) begin
      chk("mem_wr", {31'd0, mem_wr}, (pw[g] && pa[g] != OUT_A) ? 1 : 0);
      chk("mem_addr", {22'd0, mem_addr}, {22'd0, pa[g]});
      if (pw[g] && pa[g] != OUT_A) begin
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, pd[g]});
        ref_mem[pa[g][9:1]] = pd[g];
      end else if (pw[g]) begin
        ref_out = pd[g][7:0];
        o.d = ref_out; o.due = cyc + 1;
        oq.push_back(o);
      end else begin
        r.m = g;
        r.d = (pa[g] == OUT_A) ? {8'h00, ref_out} : ref_mem[pa[g][9:1]];
        r.due = cyc + 1;
        rdq.push_back(r);
      end
      last_addr = pa[g];
      if (g == own) streak = (streak < MAXB) ? streak + 1 : MAXB;
      else streak = 1;
      own = g;
      pv[g] = 0;
    end else begin
      chk("mem_wr_idle", {31'd0, mem_wr}, 0);
      chk("mem_addr_hold", {22'd0, mem_addr}, rst_val ? {22'd0, last_addr} : 0);
      streak = 0;
    end
    if (!rst_val) begin
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
      own = -1; streak = 0; ref_out = 8'h00; last_addr = 10'h000;
    end
  endtask

  // Two reset cycles with m0 asking for access the whole time
  task automatic do_reset();
    pv[0] = 1; pw[0] = 0; pa[0] = 10'h200; pd[0] = 16'h0000;
    pv[1] = 0;
    step(1'b0);
    step(1'b0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    pv[0] = 0;
  endtask

  // Response monitor: every rvalid/out_valid must match the oldest expectation
  always @(negedge clk) begin
    rd_t  e;
    out_t o;
    if (m0_rvalid && m1_rvalid) begin
      chk("rvalid_onehot", {30'd0, m1_rvalid, m0_rvalid}, 32'b01);
    end else if (m0_rvalid || m1_rvalid) begin
      if (rdq.size() == 0) chk("rd_unexpected", {30'd0, m1_rvalid, m0_rvalid}, 0);
      else begin
        e = rdq.pop_front();
        chk("rd_due", cyc, e.due);
        chk("rd_master", m1_rvalid ? 1 : 0, e.m);
        chk("rd_data", {16'd0, m1_rvalid ? m1_rdata : m0_rdata}, {16'd0, e.d});
      end
    end else if (rdq.size() > 0 && rdq[0].due <= cyc) begin
      e = rdq.pop_front();
      chk("rd_missing", {30'd0, m1_rvalid, m0_rvalid}, (e.m == 1) ? 32'b10 : 32'b01);
    end
    if (out_valid) begin
      if (oq.size() == 0) chk("out_unexpected", {31'd0, out_valid}, 0);
      else begin
        o = oq.pop_front();
        chk("out_due", cyc, o.due);
        chk("out_data", {24'd0, out_data}, {24'd0, o.d});
      end
    end else if (oq.size() > 0 && oq[0].due <= cyc) begin
      o = oq.pop_front();
      chk("out_missing", {31'd0, out_valid}, 1);
    end
  end

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 512; i++) begin
      sim_mem[i] = 16'($urandom);
      ref_mem[i] = sim_mem[i];
    end
    sim_mem[9'h100] = 16'h1234; ref_mem[9'h100] = 16'h1234;
    sim_mem[9'h080] = 16'hBEEF; ref_mem[9'h080] = 16'hBEEF;
    sim_mem[9'h081] = 16'hCAFE; ref_mem[9'h081] = 16'hCAFE;
    for (int m = 0; m < 2; m++) begin pv[m] = 0; pw[m] = 0; pa[m] = '0; pd[m] = '0; end

    do_reset();

    // m0 reads 0x200 -> word 0x100
    pv[0] = 1; pw[0] = 0; pa[0] = 10'h200;
    step(1'b1);
    chk("rd200_gnt", dut_g, 0);
    step(1'b1);
    chk("rd200_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'b01);
    chk("rd200_rdata", {16'd0, m0_rdata}, 32'h1234);

    // m1 writes the output register
    pv[1] = 1; pw[1] = 1; pa[1] = OUT_A; pd[1] = 16'h00A5;
    step(1'b1);
    step(1'b1);
    chk("outwr_valid", {31'd0, out_valid}, 1);
    chk("outwr_data", {24'd0, out_data}, 32'hA5);
    step(1'b1);
    chk("outwr_pulse", {31'd0, out_valid}, 0);

    // Read back the output register; memory bus content must not leak in
    pv[0] = 1; pw[0] = 0; pa[0] = OUT_A;
    step(1'b1);
    step(1'b1);

    // Alternating reads on consecutive cycles
    pv[0] = 1; pw[0] = 0; pa[0] = 10'h100;
    step(1'b1);
    pv[1] = 1; pw[1] = 0; pa[1] = 10'h102;
    step(1'b1);
    chk("alt_m0_rdata", {16'd0, m0_rdata}, 32'hBEEF);
    step(1'b1);
    chk("alt_m1_rdata", {16'd0, m1_rdata}, 32'hCAFE);

    // Continuous contention from IDLE
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int m = 0; m < 2; m++)
        if (!pv[m]) begin pv[m] = 1; pw[m] = 0; pa[m] = 10'($urandom_range(0, 1023)); end
      step(1'b1);
      chk("burst_seq", dut_g, exp_seq[k]);
    end
    pv[0] = 0; pv[1] = 0;
    step(1'b1);
    step(1'b1);

    // Read granted right before reset must not respond
    pv[1] = 1; pw[1] = 0; pa[1] = 10'h102;
    step(1'b1);
    step(1'b0);
    chk("rst_drop_rvalid", {31'd0, m1_rvalid}, 0);
    step(1'b0);
    pv[0] = 0; pv[1] = 0;
    step(1'b1);
    chk("rst_drop_after", {31'd0, m1_rvalid}, 0);

    // Random traffic
    rand_mode = 1;
    repeat (400) step(1'b1);
    rand_mode = 0;
    pv[0] = 0; pv[1] = 0;
    repeat (3) step(1'b1);
    chk("queues_drained", rdq.size() + oq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
